// File: rtl/gpio_event_tx.sv
`timescale 1ns/1ps
// gpio_event_tx: queues 4-bit event codes and sends them to the host over a four-phase req/ack handshake with watchdog.
// Optional feature: define GPIO_EVENT_TX_PARITY_EN to drive odd parity on tx_parity (tied to 0 otherwise).
module gpio_event_tx #(
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       evt_valid,
    input  logic [3:0] evt_code,
    output logic       evt_full,
    output logic       evt_overflow,
    output logic [3:0] tx_data,
    output logic       tx_parity,
    output logic       tx_req,
    input  logic       tx_ack,
    output logic       tx_busy,
    output logic       tx_timeout
);
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SETUP        = 3'd1,
        WAIT_ACK     = 3'd2,
        WAIT_RELEASE = 3'd3
    } state_t;

    localparam logic [25:0] SETUP_LAST   = 26'(SETUP_CYCLES - 1);
    localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [3:0]  mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [2:0]  count_next;
    logic [25:0] cnt;
    logic        ack_m;
    logic        ack_s;
    logic        pop;
    logic        push;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is only dropped without a pop
    always_comb begin
        pop        = (state == IDLE) && (count != 3'd0);
        push       = evt_valid && ((count != 3'd4) || pop);
        count_next = count + {2'b00, push} - {2'b00, pop};
    end

    // FIFO storage; stale contents are harmless because the pointers and count gate every read
    always_ff @(posedge clk_50) begin
        if (push) mem[wr_ptr] <= evt_code;
    end

    // FIFO pointers, occupancy and the registered full/overflow flags
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= 2'd0;
            rd_ptr       <= 2'd0;
            count        <= 3'd0;
            evt_full     <= 1'b0;
            evt_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count        <= count_next;
            evt_full     <= (count_next == 3'd4);
            evt_overflow <= evt_valid && !push;
        end
    end

    // Two-flop synchronizer for the host acknowledge
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= tx_ack;
            ack_s <= ack_m;
        end
    end

    // Handshake FSM with saturating phase counter and registered outputs
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 26'd0;
            tx_data    <= 4'd0;
            tx_req     <= 1'b0;
            tx_busy    <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            tx_timeout <= 1'b0;
            cnt        <= (cnt == '1) ? cnt : cnt + 26'd1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        tx_busy <= 1'b1;
                        cnt     <= 26'd0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        tx_req <= 1'b1;
                        cnt    <= 26'd0;
                        state  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s) begin
                        tx_req <= 1'b0;
                        cnt    <= 26'd0;
                        state  <= WAIT_RELEASE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        tx_req     <= 1'b0;
                        tx_timeout <= 1'b1;
                        cnt        <= 26'd0;
                        state      <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!ack_s) begin
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        tx_busy    <= 1'b0;
                        tx_timeout <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    tx_req  <= 1'b0;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef GPIO_EVENT_TX_PARITY_EN
    // Odd parity loaded alongside tx_data on every pop
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) tx_parity <= 1'b1;
        else if (pop) tx_parity <= ~^mem[rd_ptr];
    end
`else
    assign tx_parity = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_event_tx.sv
`timescale 1ns/1ps
// tb_gpio_event_tx: directed scenario tests for gpio_event_tx with a small bounded host model.
module tb_gpio_event_tx;
    localparam int SETUP = 2;
    localparam int TMO   = 100;

    logic       clk_50    = 1'b0;
    logic       rst_n     = 1'b0;
    logic       evt_valid = 1'b0;
    logic [3:0] evt_code  = 4'd0;
    logic       tx_ack    = 1'b0;
    logic       evt_full;
    logic       evt_overflow;
    logic [3:0] tx_data;
    logic       tx_parity;
    logic       tx_req;
    logic       tx_busy;
    logic       tx_timeout;
    int         checks = 0;
    int         errors = 0;

    gpio_event_tx #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_50(clk_50),
        .rst_n(rst_n),
        .evt_valid(evt_valid),
        .evt_code(evt_code),
        .evt_full(evt_full),
        .evt_overflow(evt_overflow),
        .tx_data(tx_data),
        .tx_parity(tx_parity),
        .tx_req(tx_req),
        .tx_ack(tx_ack),
        .tx_busy(tx_busy),
        .tx_timeout(tx_timeout)
    );

    always #10 clk_50 = ~clk_50;

    function automatic logic par(input logic [3:0] d);
`ifdef GPIO_EVENT_TX_PARITY_EN
        return ~^d;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic sig(input int sel);
        return (sel == 0) ? tx_req : (sel == 1) ? tx_busy : tx_timeout;
    endfunction

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic push(input logic [3:0] c);
        evt_valid = 1'b1;
        evt_code  = c;
        tick();
        evt_valid = 1'b0;
    endtask

    task automatic wait_for(input int sel, input logic v, input int limit, output bit ok, output int n);
        n = 0;
        while (n < limit && sig(sel) !== v) begin
            tick();
            n++;
        end
        ok = (sig(sel) === v);
    endtask

    task automatic host_take(output logic [3:0] c, output bit ok);
        bit a, b, d;
        int n;
        wait_for(0, 1'b1, 50, a, n);
        c = tx_data;
        tx_ack = 1'b1;
        wait_for(0, 1'b0, 10, b, n);
        tx_ack = 1'b0;
        wait_for(1, 1'b0, 10, d, n);
        ok = a && b && d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (tx_data !== 4'h0) begin errors++; $display("FAIL rst_data got %h want 0", tx_data); end
        checks++; if (tx_parity !== par(4'h0)) begin errors++; $display("FAIL rst_parity got %b want %b", tx_parity, par(4'h0)); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", tx_req); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", tx_busy); end
        checks++; if (evt_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", evt_full); end
        checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", evt_overflow); end
        checks++; if (tx_timeout !== 1'b0) begin errors++; $display("FAIL rst_tmo got %b want 0", tx_timeout); end
    endtask

    task automatic test_single();
        push(4'hA);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_n got %b want 0", tx_busy); end
        tick();
        checks++; if (tx_data !== 4'hA) begin errors++; $display("FAIL single_data got %h want a", tx_data); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", tx_busy); end
        checks++; if (tx_parity !== par(4'hA)) begin errors++; $display("FAIL single_parity got %b want %b", tx_parity, par(4'hA)); end
        tick();
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL single_req_early got %b want 0", tx_req); end
        tick();
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL single_req_rise got %b want 1", tx_req); end
        repeat (10) tick();
        tx_ack = 1'b1;
        tick();
        tick();
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL single_req_hold got %b want 1", tx_req); end
        tick();
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL single_req_fall got %b want 0", tx_req); end
        repeat (7) tick();
        tx_ack = 1'b0;
        tick();
        tick();
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold got %b want 1", tx_busy); end
        tick();
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0", tx_busy); end
        checks++; if (tx_data !== 4'hA) begin errors++; $display("FAIL single_data_hold got %h want a", tx_data); end
    endtask

    task automatic test_overflow();
        logic [3:0] c;
        bit ok;
        push(4'h1);
        push(4'h2);
        checks++; if (tx_data !== 4'h1) begin errors++; $display("FAIL ovf_first got %h want 1", tx_data); end
        push(4'h3);
        push(4'h4);
        push(4'h5);
        checks++; if (evt_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", evt_full); end
        checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", evt_overflow); end
        push(4'h6);
        checks++; if (evt_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", evt_overflow); end
        tick();
        checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", evt_overflow); end
        checks++; if (evt_full !== 1'b1) begin errors++; $display("FAIL ovf_full_hold got %b want 1", evt_full); end
        for (int i = 1; i <= 5; i++) begin
            host_take(c, ok);
            checks++; if (!ok || c !== 4'(i)) begin errors++; $display("FAIL ovf_order%0d got %h ok %0d want %h", i, c, ok, 4'(i)); end
        end
        repeat (5) tick();
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", tx_busy); end
    endtask

    task automatic test_full_pop();
        logic [3:0] exp [5] = '{4'h8, 4'h9, 4'hB, 4'hC, 4'hD};
        logic [3:0] c;
        bit ok, ok2;
        int n;
        push(4'h7);
        push(4'h8);
        push(4'h9);
        push(4'hB);
        push(4'hC);
        checks++; if (evt_full !== 1'b1) begin errors++; $display("FAIL fp_full got %b want 1", evt_full); end
        wait_for(0, 1'b1, 20, ok, n);
        tx_ack = 1'b1;
        wait_for(0, 1'b0, 10, ok2, n);
        tx_ack = 1'b0;
        checks++; if (!(ok && ok2)) begin errors++; $display("FAIL fp_handshake got %0d%0d want 11", ok, ok2); end
        repeat (3) tick();
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL fp_idle got %b want 0", tx_busy); end
        checks++; if (evt_full !== 1'b1) begin errors++; $display("FAIL fp_full_idle got %b want 1", evt_full); end
        push(4'hD);
        checks++; if (evt_overflow !== 1'b0) begin errors++; $display("FAIL fp_ovf got %b want 0", evt_overflow); end
        checks++; if (evt_full !== 1'b1) begin errors++; $display("FAIL fp_full_after got %b want 1", evt_full); end
        checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL fp_count got %0d want 4", dut.count); end
        checks++; if (tx_data !== 4'h8) begin errors++; $display("FAIL fp_pop got %h want 8", tx_data); end
        for (int i = 0; i < 5; i++) begin
            host_take(c, ok);
            checks++; if (!ok || c !== exp[i]) begin errors++; $display("FAIL fp_order%0d got %h ok %0d want %h", i, c, ok, exp[i]); end
        end
    endtask

    task automatic test_timeout();
        logic [3:0] c;
        bit ok;
        int n, hi, tmo;
        push(4'h3);
        push(4'h5);
        wait_for(0, 1'b1, 10, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_req got %b want 1", tx_req); end
        hi = 0;
        tmo = 0;
        while (tx_req === 1'b1 && hi < 200) begin
            hi++;
            tick();
            if (tx_timeout === 1'b1) tmo++;
        end
        checks++; if (hi != TMO) begin errors++; $display("FAIL tmo_req_len got %0d want %0d", hi, TMO); end
        tick();
        if (tx_timeout === 1'b1) tmo++;
        checks++; if (tmo != 1) begin errors++; $display("FAIL tmo_pulses got %0d want 1", tmo); end
        wait_for(0, 1'b1, 20, ok, n);
        checks++; if (!ok || tx_data !== 4'h5) begin errors++; $display("FAIL tmo_next got %h ok %0d want 5", tx_data, ok); end
        host_take(c, ok);
        checks++; if (!ok || c !== 4'h5) begin errors++; $display("FAIL tmo_next_take got %h ok %0d want 5", c, ok); end
    endtask

    task automatic test_stuck_ack();
        bit ok;
        int n;
        tx_ack = 1'b1;
        repeat (3) tick();
        push(4'h6);
        wait_for(0, 1'b1, 10, ok, n);
        checks++; if (!ok) begin errors++; $display("FAIL stuck_req got %b want 1", tx_req); end
        tick();
        checks++; if (tx_req !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL stuck_ackd got req %b busy %b want 0 1", tx_req, tx_busy); end
        wait_for(2, 1'b1, 200, ok, n);
        checks++; if (!ok || n != TMO) begin errors++; $display("FAIL stuck_tmo got %0d cycles ok %0d want %0d", n, ok, TMO); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL stuck_idle got %b want 0", tx_busy); end
        tick();
        checks++; if (tx_timeout !== 1'b0) begin errors++; $display("FAIL stuck_pulse got %b want 0", tx_timeout); end
        tx_ack = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        bit ok, ok2;
        int n;
        for (int i = 1; i <= 5; i++) push(4'(i));
        tx_ack = 1'b1;
        wait_for(0, 1'b0, 10, ok, n);
        tx_ack = 1'b0;
        wait_for(1, 1'b0, 10, ok2, n);
        tick();
        checks++; if (!(ok && ok2) || tx_busy !== 1'b1 || tx_data !== 4'h2) begin errors++; $display("FAIL rmid_setup got busy %b data %h want 1 2", tx_busy, tx_data); end
        checks++; if (dut.count !== 3'd3) begin errors++; $display("FAIL rmid_queued got %0d want 3", dut.count); end
        #3 rst_n = 1'b0;
        #2;
        checks++; if (tx_req !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL rmid_async got req %b busy %b want 0 0", tx_req, tx_busy); end
        checks++; if (tx_data !== 4'h0 || tx_parity !== par(4'h0)) begin errors++; $display("FAIL rmid_data got %h %b want 0 %b", tx_data, tx_parity, par(4'h0)); end
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", dut.count); end
        checks++; if (tx_busy !== 1'b0 || tx_req !== 1'b0 || tx_data !== 4'h0) begin errors++; $display("FAIL rmid_after got busy %b req %b data %h want 0 0 0", tx_busy, tx_req, tx_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_stuck_ack();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout sim time %0t limit 2000000", $time);
        $fatal(1);
    end
endmodule
